// File: rtl/instr_ctrl_unit.sv
// Multi-cycle fetch/decode control unit for an RV64I subset (LD, SD, ADDI, ADD, SUB).
// Drives the datapath control/operand inputs for one EXEC cycle per instruction.
module instr_ctrl_unit #(
    parameter int PC_W  = 10,
    parameter int IMM_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      imem_data,
    output logic [PC_W-1:0]  imem_addr,
    output logic             enable,
    output logic [4:0]       a,
    output logic [4:0]       b,
    output logic [4:0]       w,
    output logic [IMM_W-1:0] din,
    output logic             load_store,
    output logic             op_ula,
    output logic             operation_type,
    output logic             ula_entry,
    output logic             busy,
    output logic             done,
    output logic             illegal
);

    localparam logic [6:0]  OP_LD    = 7'b0000011;
    localparam logic [6:0]  OP_SD    = 7'b0100011;
    localparam logic [6:0]  OP_ADDI  = 7'b0010011;
    localparam logic [6:0]  OP_REG   = 7'b0110011;
    localparam logic [31:0] ECALL    = 32'h0000_0073;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t          state, state_next;
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic            ill_flag;
    logic            word_legal;

    always_comb begin
        word_legal = 1'b0;
        unique case (imem_data[6:0])
            OP_LD, OP_SD: word_legal = (imem_data[14:12] == 3'b011);
            OP_ADDI:      word_legal = (imem_data[14:12] == 3'b000);
            OP_REG:       word_legal = (imem_data[14:12] == 3'b000) &&
                                       ((imem_data[31:25] == 7'b0000000) ||
                                        (imem_data[31:25] == 7'b0100000));
            default:      word_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= '0;
            instr    <= '0;
            ill_flag <= 1'b0;
        end else begin
            state <= state_next;
            unique case (state)
                S_IDLE: if (start) pc <= '0;
                S_DECODE: begin
                    instr    <= imem_data;
                    ill_flag <= !word_legal && (imem_data != ECALL);
                end
                S_EXEC: pc <= pc + PC_W'(4);
                S_HALT: if (start) begin
                    pc       <= '0;
                    ill_flag <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign imem_addr = pc;

    // Outputs decode the latched instruction combinationally so an async reset clears them at once.
    always_comb begin
        state_next     = state;
        enable         = 1'b0;
        a              = '0;
        b              = '0;
        w              = '0;
        din            = '0;
        load_store     = 1'b0;
        op_ula         = 1'b0;
        operation_type = 1'b0;
        ula_entry      = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        illegal        = 1'b0;
        unique case (state)
            S_IDLE: if (start) state_next = S_FETCH;
            S_FETCH: begin
                busy       = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                busy       = 1'b1;
                state_next = word_legal ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                busy       = 1'b1;
                enable     = 1'b1;
                b          = instr[19:15];
                op_ula     = 1'b1;
                load_store = 1'b1;
                state_next = S_FETCH;
                unique case (instr[6:0])
                    OP_LD: begin
                        w   = instr[11:7];
                        din = {{(IMM_W-12){instr[31]}}, instr[31:20]};
                    end
                    OP_SD: begin
                        a          = instr[24:20];
                        load_store = 1'b0;
                        din        = {{(IMM_W-12){instr[31]}}, instr[31:25], instr[11:7]};
                    end
                    OP_ADDI: begin
                        w              = instr[11:7];
                        operation_type = 1'b1;
                        din            = {{(IMM_W-12){instr[31]}}, instr[31:20]};
                    end
                    default: begin
                        a              = instr[24:20];
                        w              = instr[11:7];
                        operation_type = 1'b1;
                        ula_entry      = 1'b1;
                        op_ula         = !instr[30];
                    end
                endcase
            end
            S_HALT: begin
                done    = !ill_flag;
                illegal = ill_flag;
                if (start) state_next = S_FETCH;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_ctrl_unit.sv
// Scoreboard bench for instr_ctrl_unit: directed programs in a synchronous ROM model,
// expected EXEC/HALT events queued by stimulus and popped by a negedge monitor.
module tb_instr_ctrl_unit;

    localparam int PC_W  = 10;
    localparam int IMM_W = 64;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [31:0]      imem_data;
    logic [PC_W-1:0]  imem_addr;
    logic             enable;
    logic [4:0]       a, b, w;
    logic [IMM_W-1:0] din;
    logic             load_store, op_ula, operation_type, ula_entry;
    logic             busy, done, illegal;

    instr_ctrl_unit #(.PC_W(PC_W), .IMM_W(IMM_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .imem_data      (imem_data),
        .imem_addr      (imem_addr),
        .enable         (enable),
        .a              (a),
        .b              (b),
        .w              (w),
        .din            (din),
        .load_store     (load_store),
        .op_ula         (op_ula),
        .operation_type (operation_type),
        .ula_entry      (ula_entry),
        .busy           (busy),
        .done           (done),
        .illegal        (illegal)
    );

    always #5 clk = ~clk;

    logic [31:0] rom [0:255];
    always @(posedge clk) imem_data <= rom[imem_addr[9:2]];

    typedef struct packed {
        logic        en;
        logic        bsy;
        logic        dn;
        logic        ill;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rw;
        logic [63:0] imm;
        logic        ls;
        logic        op;
        logic        ot;
        logic        ue;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    logic prev_halted = 1'b0;

    function automatic ev_t ex(input logic [4:0] ra, rb, rw, input logic [63:0] imm,
                               input logic ls, op, ot, ue);
        ev_t e;
        e = '{en: 1'b1, bsy: 1'b1, dn: 1'b0, ill: 1'b0, ra: ra, rb: rb, rw: rw,
              imm: imm, ls: ls, op: op, ot: ot, ue: ue};
        return e;
    endfunction

    function automatic ev_t hl(input logic ill);
        ev_t e;
        e     = '0;
        e.dn  = !ill;
        e.ill = ill;
        return e;
    endfunction

    function automatic ev_t observe();
        ev_t e;
        e = '{en: enable, bsy: busy, dn: done, ill: illegal, ra: a, rb: b, rw: w,
              imm: din, ls: load_store, op: op_ula, ot: operation_type, ue: ula_entry};
        return e;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: an EXEC cycle or entry into HALT is one observable response.
    always @(negedge clk) begin
        ev_t o, e;
        logic halted;
        o      = observe();
        halted = done | illegal;
        if (enable || (halted && !prev_halted)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", 128'(o), 128'(0));
            end else begin
                e = exp_q.pop_front();
                check(enable ? "exec_event" : "halt_event", 128'(o), 128'(e));
            end
        end
        prev_halted = halted;
    end

    task automatic reset_dut();
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        check("reset_outputs", 128'({observe(), imem_addr}), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_halt();
        int n = 0;
        while (!(done | illegal) && n < 80) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("halt_reached", 128'(done | illegal), 128'(1));
        @(negedge clk);
        #1;
        check("queue_drained", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        clear_rom();

        // Program: ld, sd, addi, add, sub, ecall
        reset_dut();
        rom[0] = 32'h0036B103;
        rom[1] = 32'h00433123;
        rom[2] = 32'hFAB18793;
        rom[3] = 32'h007302B3;
        rom[4] = 32'h40300933;
        rom[5] = 32'h00000073;
        exp_q.push_back(ex(5'd0, 5'd13, 5'd2,  64'd3,                  1'b1, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(ex(5'd4, 5'd6,  5'd0,  64'd2,                  1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(ex(5'd0, 5'd3,  5'd15, 64'hFFFF_FFFF_FFFF_FFAB, 1'b1, 1'b1, 1'b1, 1'b0));
        exp_q.push_back(ex(5'd7, 5'd6,  5'd5,  64'd0,                  1'b1, 1'b1, 1'b1, 1'b1));
        exp_q.push_back(ex(5'd3, 5'd0,  5'd18, 64'd0,                  1'b1, 1'b0, 1'b1, 1'b1));
        exp_q.push_back(hl(1'b0));
        check("idle_not_busy", 128'(busy), 128'(0));
        pulse_start();
        check("fetch_busy", 128'(busy), 128'(1));
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("pc_after_first", 128'(imem_addr), 128'(4));
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_halt();
        check("done_pc", 128'(imem_addr), 128'(20));

        // Illegal f7 after one ld, then restart from HALT
        reset_dut();
        clear_rom();
        rom[0] = 32'h0036B103;
        rom[1] = 32'h02300933;
        exp_q.push_back(ex(5'd0, 5'd13, 5'd2, 64'd3, 1'b1, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(hl(1'b1));
        pulse_start();
        wait_halt();
        check("illegal_pc_held", 128'(imem_addr), 128'(4));
        repeat (3) @(posedge clk);
        #1;
        check("halt_holds", 128'({busy, done, illegal}), 128'(3'b001));
        exp_q.push_back(ex(5'd0, 5'd13, 5'd2, 64'd3, 1'b1, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(hl(1'b1));
        pulse_start();
        check("restart_addr", 128'({imem_addr, busy, done, illegal}), 128'({10'd0, 3'b100}));
        wait_halt();

        // Illegal as the very first instruction: no enable at all
        reset_dut();
        clear_rom();
        rom[0] = 32'h02300933;
        exp_q.push_back(hl(1'b1));
        pulse_start();
        wait_halt();

        // Reset asserted during EXEC
        reset_dut();
        clear_rom();
        rom[0] = 32'h0036B103;
        rom[1] = 32'h00000073;
        exp_q.push_back(ex(5'd0, 5'd13, 5'd2, 64'd3, 1'b1, 1'b1, 1'b0, 1'b0));
        pulse_start();
        begin
            int n = 0;
            while (!enable && n < 10) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("exec_seen", 128'(enable), 128'(1));
        end
        rst_n = 1'b0;
        #1;
        check("reset_in_exec", 128'({observe(), imem_addr}), 128'(0));
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_reset", 128'({busy, done, illegal, enable, imem_addr}), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/instr_ctrl_unit.md
Name: instr_ctrl_unit

Overview:
- Multi-cycle control unit directly upstream of `datapath`.
- Fetches 32-bit RV64I-subset instructions (LD, SD, ADDI, ADD, SUB) from a synchronous instruction ROM and decodes them.
- Drives every datapath control/operand input: enable, a, b, w, din, load_store, op_ula, operation_type, ula_entry.
- Runs from a `start` pulse until ECALL or an illegal instruction, then halts.

Parameters:
- PC_W, 10, width of program counter / imem_addr (byte address).
- IMM_W, 64, width of sign-extended immediate driven on din.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; starts execution at PC=0.
- imem_data  input  32  instruction word; valid one cycle after imem_addr is presented.
- imem_addr  output  PC_W  instruction byte address (= PC).
- enable  output  1  datapath enable (register write / memory write).
- a  output  5  rs2 field (store data or second ALU operand).
- b  output  5  rs1 field (base / first ALU operand).
- w  output  5  rd field (destination register).
- din  output  IMM_W  sign-extended immediate.
- load_store  output  1  0 = store, 1 = load / register writeback.
- op_ula  output  1  1 = add, 0 = subtract (b − operand).
- operation_type  output  1  0 = memory access, 1 = arithmetic.
- ula_entry  output  1  0 = immediate operand, 1 = register a.
- busy  output  1  high from start until halt.
- done  output  1  high in HALT (normal ECALL stop).
- illegal  output  1  high in HALT if the halt was caused by an undecodable instruction.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, PC=0, instr reg=0, every output 0.
- States: IDLE, FETCH, DECODE, EXEC, HALT.
- IDLE → FETCH on start=1.
- FETCH: imem_addr=PC; → DECODE.
- DECODE: latch imem_data into instr reg; → EXEC if legal; → HALT if ECALL (0x00000073) or illegal.
- EXEC: controls valid for exactly this one cycle; PC+=4 (wraps modulo 2^PC_W); → FETCH.
- Latency: 3 cycles per instruction. enable is high only in EXEC.
- Outside EXEC: enable=0, and a, b, w, din, load_store, op_ula, operation_type, ula_entry are all 0.
- Decode rules (rs1→b, rs2→a, rd→w):
  - LD (opcode 0000011, f3 011): load_store=1, operation_type=0, ula_entry=0, op_ula=1, din=sext(instr[31:20]), a=0.
  - SD (opcode 0100011, f3 011): load_store=0, operation_type=0, ula_entry=0, op_ula=1, din=sext({instr[31:25],instr[11:7]}), w=0.
  - ADDI (opcode 0010011, f3 000): load_store=1, operation_type=1, ula_entry=0, op_ula=1, din=sext(instr[31:20]), a=0.
  - ADD / SUB (opcode 0110011, f3 000, f7 0000000 / 0100000): load_store=1, operation_type=1, ula_entry=1, op_ula=1 / 0, din=0.
  - Any other opcode/f3/f7 combination: illegal → HALT with illegal=1, done=0.
- busy=1 in FETCH/DECODE/EXEC, 0 in IDLE and HALT.
- HALT: holds until start=1, which clears done/illegal, sets PC=0 and goes to FETCH.
- start in any state other than IDLE/HALT: ignored.
- rst_n asserted mid-instruction (including EXEC): outputs drop to 0 immediately; no partial enable pulse.

Test Plan:
- Reset then start, ROM[0]=0x0036B103 (ld x2,3(x13)) → in EXEC (cycle 3 after start): enable=1, load_store=1, operation_type=0, b=13, w=2, din=3; then imem_addr=4.
- ROM[0]=0x00433123 (sd x4,2(x6)) → EXEC: load_store=0, a=4, b=6, w=0, din=2, enable=1.
- ROM[0]=0xFAB18793 (addi x15,x3,-85) → EXEC: operation_type=1, ula_entry=0, op_ula=1, b=3, w=15, din=0xFFFF_FFFF_FFFF_FFAB.
- ROM[0]=0x40300933 (sub x18,x0,x3), ROM[4]=0x00000073 → EXEC: ula_entry=1, op_ula=0, a=3, b=0, w=18; next instruction → done=1, busy=0, illegal=0, enable stays 0.
- ROM[0]=0x02300933 (f7 = 0000001) → HALT with illegal=1, done=0, enable never asserted; a start pulse restarts at imem_addr=0.
- rst_n pulsed low during EXEC → all outputs 0 in the same cycle; state IDLE; PC=0.
